// File: rtl/mac_custom_instruction.sv
// Iterative shift-add multiply / multiply-accumulate custom instruction.
// Optional MAC_SAT_EN: saturating accumulate with a sticky flag read back by opcode 7.
module mac_custom_instruction #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [2:0]       n,
    input  logic [WIDTH-1:0] dataa,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StBusy, StFinish} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic [W2-1:0]     prod_q, prod_d, acc_q, acc_d;
    logic [W2-1:0]     mcand_q, mcand_d, psum_q, psum_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sign_q, sign_d, mac_q, mac_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              sat_q, sat_d;

    logic [WIDTH-1:0]  abs_a, abs_b;
    logic [W2-1:0]     final_p, acc_new;
    logic              sat_hit;

    assign abs_a   = opa_q[WIDTH-1] ? (~opa_q + 1'b1) : opa_q;
    assign abs_b   = opb_q[WIDTH-1] ? (~opb_q + 1'b1) : opb_q;
    assign final_p = sign_q ? (~psum_q + 1'b1) : psum_q;

`ifdef MAC_SAT_EN
    logic [W2:0] acc_ext;
    always_comb begin
        // One guard bit: overflow when the two top bits disagree.
        acc_ext = {acc_q[W2-1], acc_q} + {final_p[W2-1], final_p};
        sat_hit = acc_ext[W2] != acc_ext[W2-1];
        if (!sat_hit) begin
            acc_new = acc_ext[W2-1:0];
        end else if (acc_ext[W2]) begin
            acc_new = {1'b1, {(W2-1){1'b0}}};
        end else begin
            acc_new = {1'b0, {(W2-1){1'b1}}};
        end
    end
`else
    always_comb begin
        acc_new = acc_q + final_p;
        sat_hit = 1'b0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        psum_d   = psum_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        mac_d    = mac_q;
        result_d = result_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (n)
                        3'd0: begin opa_d = dataa; result_d = '0; done_d = 1'b1; end
                        3'd1: begin opb_d = dataa; result_d = '0; done_d = 1'b1; end
                        3'd3: begin result_d = prod_q[W2-1:WIDTH]; done_d = 1'b1; end
                        3'd5: begin result_d = acc_q[WIDTH-1:0]; done_d = 1'b1; end
                        3'd6: begin result_d = acc_q[W2-1:WIDTH]; done_d = 1'b1; end
                        3'd7: begin
                            acc_d    = '0;
                            sat_d    = 1'b0;
                            result_d = {{(WIDTH-1){1'b0}}, sat_q};
                            done_d   = 1'b1;
                        end
                        default: begin
                            // n = 2 or 4: launch the shift-add engine on magnitudes.
                            mcand_d  = {{WIDTH{1'b0}}, abs_a};
                            mplier_d = abs_b;
                            psum_d   = '0;
                            cnt_d    = '0;
                            sign_d   = opa_q[WIDTH-1] ^ opb_q[WIDTH-1];
                            mac_d    = n[2];
                            state_d  = StBusy;
                        end
                    endcase
                end
            end
            StBusy: begin
                if (mplier_q[0]) begin
                    psum_d = psum_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                prod_d  = final_p;
                done_d  = 1'b1;
                state_d = StIdle;
                if (mac_q) begin
                    acc_d    = acc_new;
                    sat_d    = sat_q | sat_hit;
                    result_d = acc_new[WIDTH-1:0];
                end else begin
                    result_d = final_p[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            opa_q    <= '0;
            opb_q    <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            psum_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            mac_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            psum_q   <= psum_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            mac_q    <= mac_d;
            done_q   <= done_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_mac_custom_instruction.sv
// Randomised self-checking bench for mac_custom_instruction against an arithmetic model.
module tb_mac_custom_instruction;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         clk_en = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   n = 3'd0;
    logic [W-1:0] dataa = '0;
    logic         done;
    logic [W-1:0] result;

    int n_total = 0;
    int n_bad = 0;

    // Reference model state
    logic [W-1:0]   m_a, m_b, m_res;
    logic [2*W-1:0] m_prod, m_acc;
    bit             m_sat;

    mac_custom_instruction #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0; m_prod = '0; m_acc = '0; m_sat = 0; m_res = '0;
    endtask

    task automatic model_exec(input logic [2:0] op, input logic [W-1:0] d);
        longint sa, sb, p;
        logic [2*W-1:0] sum;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        p  = sa * sb;
        case (op)
            3'd0: begin m_a = d; m_res = '0; end
            3'd1: begin m_b = d; m_res = '0; end
            3'd2: begin m_prod = p; m_res = m_prod[W-1:0]; end
            3'd3: m_res = m_prod[2*W-1:W];
            3'd4: begin
                m_prod = p;
                sum = m_acc + m_prod;
`ifdef MAC_SAT_EN
                if (m_acc[63] == m_prod[63] && sum[63] != m_acc[63]) begin
                    m_sat = 1;
                    sum = m_acc[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
                end
`endif
                m_acc = sum;
                m_res = m_acc[W-1:0];
            end
            3'd5: m_res = m_acc[W-1:0];
            3'd6: m_res = m_acc[2*W-1:W];
            default: begin
`ifdef MAC_SAT_EN
                m_res = {31'd0, m_sat};
`else
                m_res = '0;
`endif
                m_acc = '0;
                m_sat = 0;
            end
        endcase
    endtask

    // Issue one command, wait (bounded) for done; lat counts enabled edges incl. the start edge.
    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] d,
                          output logic [W-1:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; n = op; dataa = d; clk_en = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = result;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] d);
        logic [W-1:0] res;
        int lat;
        do_cmd(op, d, res, lat);
        model_exec(op, d);
        check_eq({tag, ".lat"}, 64'(lat), (op == 3'd2 || op == 3'd4) ? 64'd34 : 64'd1);
        check_eq({tag, ".res"}, 64'(res), 64'(m_res));
    endtask

    function automatic logic [W-1:0] pick_data();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h0;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] res;
        int lat;
        model_reset();
        // Reset must win even while clk_en is low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset.done", 64'(done), 64'd0);
        check_eq("reset.result", 64'(result), 64'd0);
        reset = 1'b0;
        clk_en = 1'b1;

        run("a3", 3'd0, 32'd3);
        run("b4", 3'd1, 32'd4);
        run("mul12", 3'd2, '0);
        check_eq("mul12.const", 64'(result), 64'd12);
        run("mul12hi", 3'd3, '0);

        run("a10", 3'd0, 32'd10);
        run("bm150", 3'd1, 32'hFFFF_FF6A);
        run("mulneg", 3'd2, '0);
        check_eq("mulneg.const", 64'(result), 64'hFFFF_FA24);
        run("mulneghi", 3'd3, '0);
        check_eq("mulneghi.const", 64'(result), 64'hFFFF_FFFF);

        run("amin", 3'd0, 32'h8000_0000);
        run("bmin", 3'd1, 32'h8000_0000);
        run("mulmin", 3'd2, '0);
        run("mulminhi", 3'd3, '0);
        check_eq("mulminhi.const", 64'(result), 64'h4000_0000);

        run("clr", 3'd7, '0);
        run("a1000", 3'd0, 32'd1000);
        run("bm3", 3'd1, 32'hFFFF_FFFD);
        run("mac1", 3'd4, '0);
        run("mac2", 3'd4, '0);
        check_eq("mac2.const", 64'(result), 64'hFFFF_E890);
        run("mac2hi", 3'd6, '0);
        check_eq("mac2hi.const", 64'(result), 64'hFFFF_FFFF);

        // Operand write during BUSY must be dropped and give no done.
        @(negedge clk);
        start = 1'b1; n = 3'd2;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin @(posedge clk); lat++; end
        @(negedge clk);
        start = 1'b1; n = 3'd0; dataa = 32'd99;
        @(posedge clk);
        lat++;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy.nodone", 64'(done), 64'd0);
        while (!done && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
        model_exec(3'd2, '0);
        check_eq("busy.lat", 64'(lat), 64'd34);
        check_eq("busy.res", 64'(result), 64'(m_res));
        run("busy.remul", 3'd2, '0);

        // Stall the engine for 5 cycles with clk_en low; then stretch done.
        @(negedge clk);
        start = 1'b1; n = 3'd2;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) begin @(posedge clk); lat++; end
        @(negedge clk);
        clk_en = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        clk_en = 1'b1;
        while (!done && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
        model_exec(3'd2, '0);
        check_eq("stall.lat", 64'(lat), 64'd34);
        check_eq("stall.res", 64'(result), 64'(m_res));
        clk_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("stretch.done", 64'(done), 64'd1);
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("stretch.fall", 64'(done), 64'd0);

        // Reset in the middle of BUSY aborts silently.
        @(negedge clk);
        start = 1'b1; n = 3'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        lat = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) lat++;
        end
        check_eq("abort.dones", 64'(lat), 64'd0);
        check_eq("abort.result", 64'(result), 64'd0);
        run("abort.acc", 3'd5, '0);

        // Drive the accumulator past the positive limit.
        run("sat.clr", 3'd7, '0);
        run("sat.a", 3'd0, 32'h7FFF_FFFF);
        run("sat.b", 3'd1, 32'h7FFF_FFFF);
        for (int i = 0; i < 3; i++) run("sat.mac", 3'd4, '0);
        run("sat.lo", 3'd5, '0);
        run("sat.hi", 3'd6, '0);
`ifdef MAC_SAT_EN
        check_eq("sat.hi.const", 64'(result), 64'h7FFF_FFFF);
        run("sat.flag", 3'd7, '0);
        check_eq("sat.flag.const", 64'(result), 64'd1);
`else
        check_eq("wrap.hi.const", 64'(result), 64'hBFFF_FFFD);
        run("wrap.clr", 3'd7, '0);
        check_eq("wrap.clr.const", 64'(result), 64'd0);
`endif

        for (int i = 0; i < 200; i++) begin
            run("rnd", 3'($urandom_range(0, 7)), pick_data());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
